// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
// Shared definitions for the scanning sensor-input multiplexer:
//   - state_e   : controller states (IDLE / MANUAL / SCAN)
//   - sel_width : width of a channel index for a given channel count (at least 1 bit)
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_e;

    // A channel index needs at least one bit, even for a degenerate count.
    function automatic int sel_width(input int channels);
        int w;
        w = $clog2(channels);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// dwell_counter
// Counts the cycles spent on one scan channel and reports when the dwell
// period is complete.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset (count -> 0)
//   clear : synchronous clear, takes priority over run
//   run   : advance the count this cycle
//   tick  : high when the count is DWELL-1 and run is high; the count wraps to 0
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int                 CNT_W    = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_r;

    // Dwell period completes on the last count of an active cycle.
    always_comb begin
        tick = run && (cnt_r == LAST_CNT);
    end

    // Dwell count register: clear, advance, or wrap on tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (run) begin
            if (tick) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1
// N-channel, W-bit registered multiplexer with an automatic scan mode.
// Manual mode forwards the channel addressed by sel; scan mode steps through
// every channel, holding each for DWELL cycles, and flags the settled sample.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-high reset
//   in_bus    : CHANNELS*WIDTH input bank, channel k at [k*WIDTH +: WIDTH]
//   sel       : manual channel select
//   mode      : 0 = manual, 1 = scan
//   enable    : 0 = idle
//   out       : registered selected data
//   out_ch    : index of the channel currently in out
//   valid     : out holds a settled sample
//   scan_done : one-cycle pulse with the last channel's valid of a sweep
module mux_scan_nx1
    import mux_scan_pkg::*;
#(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      enable,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      valid,
    output logic                      scan_done
);

    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   CH_COUNT = (SEL_W + 1)'(CHANNELS);

    state_e             state_r;
    state_e             next_state_s;
    logic [SEL_W-1:0]   cur_r;
    logic [SEL_W-1:0]   cur_d_s;
    logic [WIDTH-1:0]   out_d_s;
    logic [SEL_W-1:0]   out_ch_d_s;
    logic               valid_d_s;
    logic               scan_done_d_s;
    logic               scan_entry_s;
    logic               scan_run_s;
    logic               sel_ok_s;
    logic               tick_s;

    // Channel extraction; indices past the last channel yield zero (never used).
    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] bus,
                                              input logic [SEL_W-1:0] idx);
        logic [WIDTH-1:0] r;
        r = {WIDTH{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                r = bus[k*WIDTH +: WIDTH];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state depends only on enable/mode, evaluated every edge.
    always_comb begin
        next_state_s = IDLE;
        if (!enable) begin
            next_state_s = IDLE;
        end else if (!mode) begin
            next_state_s = MANUAL;
        end else begin
            next_state_s = SCAN;
        end
    end

    // Scan qualifiers: the entry edge restarts the sweep, later edges advance it.
    always_comb begin
        scan_entry_s = (next_state_s == SCAN) && (state_r != SCAN);
        scan_run_s   = (next_state_s == SCAN) && (state_r == SCAN);
        sel_ok_s     = ({1'b0, sel} < CH_COUNT);
    end

    // The dwell count is held at zero outside an active sweep, so any
    // interruption discards a partial dwell.
    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clear (!scan_run_s),
        .run   (scan_run_s),
        .tick  (tick_s)
    );

    // Output/next-value logic, keyed on the state being entered at this edge
    // so that every input change is visible after exactly one edge.
    always_comb begin
        out_d_s       = out;
        out_ch_d_s    = out_ch;
        valid_d_s     = 1'b0;
        scan_done_d_s = 1'b0;
        cur_d_s       = {SEL_W{1'b0}};
        case (next_state_s)
            IDLE: begin
                out_d_s    = out;
                out_ch_d_s = out_ch;
            end
            MANUAL: begin
                if (sel_ok_s) begin
                    out_d_s    = pick(in_bus, sel);
                    out_ch_d_s = sel;
                    valid_d_s  = 1'b1;
                end else begin
                    out_d_s    = out;
                    out_ch_d_s = out_ch;
                    valid_d_s  = 1'b0;
                end
            end
            SCAN: begin
                if (scan_entry_s) begin
                    out_d_s    = pick(in_bus, {SEL_W{1'b0}});
                    out_ch_d_s = {SEL_W{1'b0}};
                    cur_d_s    = {SEL_W{1'b0}};
                end else begin
                    out_d_s    = pick(in_bus, cur_r);
                    out_ch_d_s = cur_r;
                    if (tick_s) begin
                        valid_d_s     = 1'b1;
                        scan_done_d_s = (cur_r == LAST_CH);
                        // Explicit wrap: CHANNELS need not be a power of two.
                        if (cur_r == LAST_CH) begin
                            cur_d_s = {SEL_W{1'b0}};
                        end else begin
                            cur_d_s = cur_r + SEL_W'(1);
                        end
                    end else begin
                        cur_d_s = cur_r;
                    end
                end
            end
            default: begin
                out_d_s    = out;
                out_ch_d_s = out_ch;
            end
        endcase
    end

    // Output and scan-position registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= {WIDTH{1'b0}};
            out_ch    <= {SEL_W{1'b0}};
            valid     <= 1'b0;
            scan_done <= 1'b0;
            cur_r     <= {SEL_W{1'b0}};
        end else begin
            out       <= out_d_s;
            out_ch    <= out_ch_d_s;
            valid     <= valid_d_s;
            scan_done <= scan_done_d_s;
            cur_r     <= cur_d_s;
        end
    end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb_mux_scan_nx1
// Drives three instances (A: 4 ch / dwell 3, B: 3 ch / dwell 2, C: 4 ch / dwell 1)
// from one stimulus stream and checks each against a per-cycle reference model
// expressed in terms of elapsed scan time, plus a table of hand-computed
// vectors for instance A and a few directed corner sequences.
module tb_mux_scan_nx1;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_bus;

    logic [7:0] out_a, out_b, out_c;
    logic [1:0] ch_a, ch_b, ch_c;
    logic       v_a, v_b, v_c;
    logic       d_a, d_b, d_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_scan_nx1 #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) dut_a (
        .clk(clk), .reset(reset), .in_bus(in_bus), .sel(sel), .mode(mode),
        .enable(enable), .out(out_a), .out_ch(ch_a), .valid(v_a), .scan_done(d_a));

    mux_scan_nx1 #(.WIDTH(8), .CHANNELS(3), .DWELL(2)) dut_b (
        .clk(clk), .reset(reset), .in_bus(in_bus[23:0]), .sel(sel), .mode(mode),
        .enable(enable), .out(out_b), .out_ch(ch_b), .valid(v_b), .scan_done(d_b));

    mux_scan_nx1 #(.WIDTH(8), .CHANNELS(4), .DWELL(1)) dut_c (
        .clk(clk), .reset(reset), .in_bus(in_bus), .sel(sel), .mode(mode),
        .enable(enable), .out(out_c), .out_ch(ch_c), .valid(v_c), .scan_done(d_c));

    // ---------------- reference model ----------------
    int       n_ch[3] = '{4, 3, 4};
    int       n_dw[3] = '{3, 2, 1};
    bit [7:0] e_out[3];
    int       e_ch[3];
    bit       e_v[3];
    bit       e_d[3];
    bit       m_scan[3];
    int       m_k[3];

    function automatic bit [7:0] chan_val(input int c);
        return 8'(in_bus >> (c * 8));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            e_out[i] = 8'h00; e_ch[i] = 0; e_v[i] = 1'b0; e_d[i] = 1'b0;
            m_scan[i] = 1'b0; m_k[i] = 0;
        end
    endtask

    // Predict the outputs after the coming edge from the current inputs.
    // In a sweep, edge k after entry shows channel floor((k-1)/D) mod N and
    // is settled when k is a multiple of D.
    task automatic model_edge();
        int c;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                e_out[i] = 8'h00; e_ch[i] = 0; e_v[i] = 1'b0; e_d[i] = 1'b0;
                m_scan[i] = 1'b0;
            end else if (!enable) begin
                e_v[i] = 1'b0; e_d[i] = 1'b0; m_scan[i] = 1'b0;
            end else if (!mode) begin
                m_scan[i] = 1'b0; e_d[i] = 1'b0;
                if (int'(sel) < n_ch[i]) begin
                    e_out[i] = chan_val(int'(sel)); e_ch[i] = int'(sel); e_v[i] = 1'b1;
                end else begin
                    e_v[i] = 1'b0;
                end
            end else if (!m_scan[i]) begin
                m_scan[i] = 1'b1; m_k[i] = 0;
                e_out[i] = chan_val(0); e_ch[i] = 0; e_v[i] = 1'b0; e_d[i] = 1'b0;
            end else begin
                m_k[i] = m_k[i] + 1;
                c = ((m_k[i] - 1) / n_dw[i]) % n_ch[i];
                e_out[i] = chan_val(c); e_ch[i] = c;
                e_v[i] = ((m_k[i] % n_dw[i]) == 0);
                e_d[i] = e_v[i] && (c == n_ch[i] - 1);
            end
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic read_dut(input int i, output int o, output int c, output int v, output int d);
        case (i)
            0:       begin o = int'(out_a); c = int'(ch_a); v = int'(v_a); d = int'(d_a); end
            1:       begin o = int'(out_b); c = int'(ch_b); v = int'(v_b); d = int'(d_b); end
            2:       begin o = int'(out_c); c = int'(ch_c); v = int'(v_c); d = int'(d_c); end
            default: begin o = -1; c = -1; v = -1; d = -1; end
        endcase
    endtask

    task automatic compare_all();
        int o, c, v, d;
        for (int i = 0; i < 3; i++) begin
            read_dut(i, o, c, v, d);
            check($sformatf("out[%0d]", i),       o, int'(e_out[i]));
            check($sformatf("out_ch[%0d]", i),    c, e_ch[i]);
            check($sformatf("valid[%0d]", i),     v, int'(e_v[i]));
            check($sformatf("scan_done[%0d]", i), d, int'(e_d[i]));
        end
    endtask

    // One clock edge: predict, advance, sample 1 time unit after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // ---------------- table of vectors for instance A ----------------
    typedef struct {
        bit       en;
        bit       md;
        bit [1:0] sl;
        bit [7:0] eo;
        int       ec;
        bit       ev;
        bit       ed;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit en, input bit md, input bit [1:0] sl,
                       input bit [7:0] eo, input int ec, input bit ev, input bit ed);
        vec_t r;
        r.en = en; r.md = md; r.sl = sl; r.eo = eo; r.ec = ec; r.ev = ev; r.ed = ed;
        vecs.push_back(r);
    endtask

    initial begin
        int vcount;
        int seen;
        reset = 1'b1; enable = 1'b0; mode = 1'b0; sel = 2'd0; in_bus = 32'h0;
        model_reset();

        // Reset and idle.
        step(); step();
        reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            check("idle_out", int'(out_a), 0);
            check("idle_valid", int'(v_a), 0);
        end

        // Manual selection and an entire sweep with known constants.
        in_bus = 32'h44332211;
        add(1'b0, 1'b0, 2'd0, 8'h00, 0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 2'd2, 8'h33, 2, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd0, 8'h11, 0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd3, 8'h44, 3, 1'b1, 1'b0);
        add(1'b0, 1'b0, 2'd3, 8'h44, 3, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'd0, 8'h11, 0, 1'b0, 1'b0);   // scan entry edge
        add(1'b1, 1'b1, 2'd0, 8'h11, 0, 1'b0, 1'b0);   // edge 1
        add(1'b1, 1'b1, 2'd0, 8'h11, 0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'd0, 8'h11, 0, 1'b1, 1'b0);   // edge 3
        add(1'b1, 1'b1, 2'd0, 8'h22, 1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'd0, 8'h22, 1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'd0, 8'h22, 1, 1'b1, 1'b0);   // edge 6
        add(1'b1, 1'b1, 2'd0, 8'h33, 2, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'd0, 8'h33, 2, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'd0, 8'h33, 2, 1'b1, 1'b0);   // edge 9
        add(1'b1, 1'b1, 2'd0, 8'h44, 3, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'd0, 8'h44, 3, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'd0, 8'h44, 3, 1'b1, 1'b1);   // edge 12, sweep done
        add(1'b1, 1'b1, 2'd0, 8'h11, 0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'd0, 8'h11, 0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'd0, 8'h11, 0, 1'b1, 1'b0);   // edge 15, second sweep
        for (int i = 0; i < vecs.size(); i++) begin
            enable = vecs[i].en; mode = vecs[i].md; sel = vecs[i].sl;
            step();
            check($sformatf("vec%0d_out", i),   int'(out_a), int'(vecs[i].eo));
            check($sformatf("vec%0d_ch", i),    int'(ch_a),  vecs[i].ec);
            check($sformatf("vec%0d_valid", i), int'(v_a),   int'(vecs[i].ev));
            check($sformatf("vec%0d_done", i),  int'(d_a),   int'(vecs[i].ed));
            // Out-of-range select on the 3-channel instance holds ch0's value.
            if (i == 3) begin
                check("oor_out_b", int'(out_b), 8'h11);
                check("oor_valid_b", int'(v_b), 0);
            end
        end

        // Interrupt: a partial dwell is abandoned and the sweep restarts at ch0.
        mode = 1'b0; step();
        mode = 1'b1; step();                       // entry
        step(); step(); step();                    // edges 1..3, edge 3 valid
        mode = 1'b0; step();                       // edge 4 turns manual
        mode = 1'b1; step();                       // fresh entry
        check("intr_entry_ch", int'(ch_a), 0);
        check("intr_entry_valid", int'(v_a), 0);
        step();
        check("intr_partial_valid", int'(v_a), 0);
        step();
        check("intr_partial_valid2", int'(v_a), 0);
        step();
        check("intr_restart_valid", int'(v_a), 1);
        check("intr_restart_out", int'(out_a), 8'h11);

        // Asynchronous reset between edges clears outputs at once.
        step(); step();
        #2 reset = 1'b1;
        #1;
        check("arst_out_a", int'(out_a), 0);
        check("arst_ch_a", int'(ch_a), 0);
        check("arst_valid_c", int'(v_c), 0);
        check("arst_out_b", int'(out_b), 0);
        model_reset();
        step();
        reset = 1'b0; enable = 1'b0;
        step(); step();
        check("post_rst_idle_valid", int'(v_a), 0);

        // Dwell of one: valid on every scan cycle, channel advances each edge.
        enable = 1'b1; mode = 1'b1;
        step();
        vcount = 0; seen = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            vcount += int'(v_c);
            check($sformatf("dw1_ch%0d", n), int'(ch_c), n % 4);
        end
        check("dw1_valid_count", vcount, 8);

        // Randomized stimulus against the model.
        for (int n = 0; n < 800; n++) begin
            enable = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 24) == 0) mode = ~mode;
            sel = 2'($urandom);
            if ($urandom_range(0, 3) == 0) in_bus = $urandom;
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b1;
                #1;
                model_reset();
                check("rand_arst_valid", int'(v_a), 0);
                #1 reset = 1'b0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
